// File: rtl/attn_pkg.sv
// -----------------------------------------------------------------------------
// attn_pkg
// Shared types and sizing helpers for the attention softmax scheduler slice.
//   sched_state_t : scheduler FSM state encoding
//   idx_width()   : index width for a count, never narrower than one bit
//   *_DEFAULT     : default head/row counts and the index widths they imply
// -----------------------------------------------------------------------------
package attn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } sched_state_t;

  // $clog2(1) is 0, which would give a zero-width port when SEQ_LEN=1.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int NUM_HEADS_DEFAULT = 4;
  localparam int SEQ_LEN_DEFAULT   = 64;
  localparam int CNT_W_DEFAULT     = 24;
  localparam int HEAD_W_DEFAULT    = idx_width(NUM_HEADS_DEFAULT);
  localparam int ROW_W_DEFAULT     = idx_width(SEQ_LEN_DEFAULT);

endpackage

// File: rtl/softmax_head_scheduler_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin pick: the first set req bit at or after
// ptr, wrapping around to bit 0.
//   req   in  N   request vector
//   ptr   in  PW  highest-priority index this round
//   gnt   out N   one-hot winner (zero when no request)
//   valid out 1   at least one request present
// -----------------------------------------------------------------------------
module rr_arbiter
  import attn_pkg::*;
#(
  parameter int  N  = 4,
  localparam int PW = idx_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  logic [N-1:0] mask_hi;
  logic [N-1:0] req_hi;
  logic [N-1:0] pick_hi;
  logic [N-1:0] pick_all;

  // Bits at or above the pointer form the first search window.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    assign mask_hi[gi] = (gi >= int'(ptr));
  end

  assign req_hi = req & mask_hi;

  // x & -x isolates the lowest set bit. If nothing is set at/after ptr the
  // search wraps, which is the lowest set bit of the whole vector.
  assign pick_hi  = req_hi & (~req_hi + N'(1));
  assign pick_all = req & (~req + N'(1));

  assign gnt   = (|req_hi) ? pick_hi : pick_all;
  assign valid = |req;

endmodule

// File: rtl/softmax_head_scheduler.sv
// -----------------------------------------------------------------------------
// softmax_head_scheduler
// Shares one row-wise softmax engine between NUM_HEADS attention heads. Heads
// are granted round-robin for a whole SEQ_LEN x SEQ_LEN matrix; each row is
// one engine job started with a single eng_start pulse.
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req        in   level request per head, held until ack
//   ack        out  one-cycle pulse on the served head when its matrix is done
//   grant      out  one-hot engine owner, zero when idle
//   eng_start  out  one-cycle pulse: engine starts row eng_row of eng_head
//   eng_head   out  head index of the current job
//   eng_row    out  row index of the current job
//   eng_done   in   one-cycle pulse from the engine: row finished
//   busy       out  high whenever the FSM is not IDLE
//   job_cycles out  grant-to-ack cycle count of the last completed matrix
// -----------------------------------------------------------------------------
module softmax_head_scheduler
  import attn_pkg::*;
#(
  parameter int  NUM_HEADS = NUM_HEADS_DEFAULT,
  parameter int  SEQ_LEN   = SEQ_LEN_DEFAULT,
  parameter int  CNT_W     = CNT_W_DEFAULT,
  localparam int HEAD_W    = idx_width(NUM_HEADS),
  localparam int ROW_W     = idx_width(SEQ_LEN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_HEADS-1:0] req,
  output logic [NUM_HEADS-1:0] ack,
  output logic [NUM_HEADS-1:0] grant,
  output logic                 eng_start,
  output logic [HEAD_W-1:0]    eng_head,
  output logic [ROW_W-1:0]     eng_row,
  input  logic                 eng_done,
  output logic                 busy,
  output logic [CNT_W-1:0]     job_cycles
);

  sched_state_t state_reg, state_next;

  logic [NUM_HEADS-1:0] grant_reg;
  logic [HEAD_W-1:0]    head_reg;
  logic [HEAD_W-1:0]    rr_ptr_reg;
  logic [ROW_W-1:0]     row_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CNT_W-1:0]     job_cycles_reg;

  logic [NUM_HEADS-1:0] arb_gnt;
  logic                 arb_valid;
  logic [HEAD_W-1:0]    arb_idx;
  logic                 last_row;

  rr_arbiter #(
    .N(NUM_HEADS)
  ) u_arb (
    .req  (req),
    .ptr  (rr_ptr_reg),
    .gnt  (arb_gnt),
    .valid(arb_valid)
  );

  // One-hot to index for the winning head.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_HEADS; i++) begin
      if (arb_gnt[i]) arb_idx = HEAD_W'(i);
    end
  end

  assign last_row = (row_reg == ROW_W'(SEQ_LEN - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. eng_done only matters in WAIT; anywhere else it is
  // deliberately ignored so a stale pulse after reset cannot advance a job.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (arb_valid) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (eng_done) state_next = last_row ? DONE : ISSUE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Job datapath: owner, row index, pointer and cycle counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_reg      <= '0;
      head_reg       <= '0;
      rr_ptr_reg     <= '0;
      row_reg        <= '0;
      cnt_reg        <= '0;
      job_cycles_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // The arbiter result is captured only here, so req changes during
          // a job never disturb the current owner.
          if (arb_valid) begin
            grant_reg <= arb_gnt;
            head_reg  <= arb_idx;
            row_reg   <= '0;
            cnt_reg   <= '0;
          end
        end
        WAIT: begin
          if (eng_done && !last_row) row_reg <= row_reg + ROW_W'(1);
        end
        DONE: begin
          job_cycles_reg <= cnt_reg;
          grant_reg      <= '0;
          // Move past the served head so continuous requesters alternate.
          rr_ptr_reg     <= (head_reg == HEAD_W'(NUM_HEADS - 1)) ?
                            '0 : head_reg + HEAD_W'(1);
        end
        default: ;
      endcase

      // Saturating count of every non-IDLE cycle.
      if (state_reg != IDLE && cnt_reg != '1) cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  // Moore outputs decoded from the registered state.
  always_comb begin
    eng_start = (state_reg == ISSUE);
    busy      = (state_reg != IDLE);
    ack       = (state_reg == DONE) ? grant_reg : '0;
  end

  assign grant      = grant_reg;
  assign eng_head   = head_reg;
  assign eng_row    = row_reg;
  assign job_cycles = job_cycles_reg;

endmodule
